// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - per-channel synchronizer plus 4-state stable-count debounce FSM
module button_debouncer #(
    parameter int N             = 2,
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] btn_out
);

    // Counter is wide enough to hold STABLE_CYCLES, but only ever reaches STABLE_CYCLES-1.
    localparam int            CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    // Bit 1 of the encoding is the accepted level, bit 0 marks a pending change.
    typedef enum logic [1:0] {
        LOW       = 2'b00,
        PEND_HIGH = 2'b01,
        HIGH      = 2'b10,
        PEND_LOW  = 2'b11
    } state_t;

    logic [N-1:0] sync1;
    logic [N-1:0] sync2;

    // Two-flop synchronizer for every raw button level before any decision logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_chan
            state_t        state;
            state_t        state_next;
            logic [CW-1:0] cnt;
            logic [CW-1:0] cnt_next;
            logic          out_q;
            logic          out_next;
            logic          s;

            assign s = sync2[i];

            // State and run-length counter registers; reset discards any pending change.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state <= LOW;
                    cnt   <= CNT_ZERO;
                end else begin
                    state <= state_next;
                    cnt   <= cnt_next;
                end
            end

            // Next state: a sample that disagrees with the accepted level opens a pending
            // window, any agreeing sample inside it aborts the window and clears the count.
            always_comb begin
                state_next = state;
                cnt_next   = cnt;
                case (state)
                    LOW: begin
                        if (s) begin
                            state_next = PEND_HIGH;
                            cnt_next   = CNT_ONE;
                        end else begin
                            cnt_next   = CNT_ZERO;
                        end
                    end
                    PEND_HIGH: begin
                        if (!s) begin
                            state_next = LOW;
                            cnt_next   = CNT_ZERO;
                        end else if (cnt == CNT_LAST) begin
                            state_next = HIGH;
                            cnt_next   = CNT_ZERO;
                        end else begin
                            cnt_next   = cnt + CNT_ONE;
                        end
                    end
                    HIGH: begin
                        if (!s) begin
                            state_next = PEND_LOW;
                            cnt_next   = CNT_ONE;
                        end else begin
                            cnt_next   = CNT_ZERO;
                        end
                    end
                    PEND_LOW: begin
                        if (s) begin
                            state_next = HIGH;
                            cnt_next   = CNT_ZERO;
                        end else if (cnt == CNT_LAST) begin
                            state_next = LOW;
                            cnt_next   = CNT_ZERO;
                        end else begin
                            cnt_next   = cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state_next = LOW;
                        cnt_next   = CNT_ZERO;
                    end
                endcase
            end

            // Output decode of the upcoming state so the registered level changes on the
            // same edge that accepts the final stable sample.
            always_comb begin
                out_next = 1'b0;
                case (state_next)
                    HIGH, PEND_LOW: out_next = 1'b1;
                    default:        out_next = 1'b0;
                endcase
            end

            // Debounced level flop; btn_out comes straight from here.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_q <= 1'b0;
                end else begin
                    out_q <= out_next;
                end
            end

            assign btn_out[i] = out_q;
        end
    endgenerate

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - scoreboard bench for button_debouncer with STABLE_CYCLES=4, N=2
module tb_button_debouncer;

    logic       clk;
    logic       rst;
    logic [1:0] btn_in;
    logic [1:0] btn_out;

    button_debouncer #(
        .N             (2),
        .STABLE_CYCLES (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_in  (btn_in),
        .btn_out (btn_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] want;
        int         id;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vec_count = 0;
    int   miss      = 0;
    int   step_id   = 0;

    // Each step drives inputs at a negedge and queues the btn_out expected after the next posedge.
    task automatic run(input int n, input logic [1:0] in, input logic r, input logic [1:0] want);
        exp_t e;
        for (int j = 0; j < n; j++) begin
            rst    = r;
            btn_in = in;
            e.want = want;
            e.id   = step_id;
            sb.push_back(e);
            step_id++;
            @(negedge clk);
        end
    endtask

    // Monitor: after every posedge, pop one expectation and compare.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            vec_count++;
            if (btn_out !== mon_e.want) begin
                miss++;
                $display("FAIL step %0d btn_out: got %b expected %b", mon_e.id, btn_out, mon_e.want);
            end
        end
    end

    initial begin
        rst    = 1'b1;
        btn_in = 2'b00;
        @(negedge clk);

        // Reset held with both buttons pressed, then released with buttons up.
        run(3, 2'b11, 1'b1, 2'b00);
        run(6, 2'b00, 1'b0, 2'b00);

        // Clean press on channel 0: output rises on the 6th edge (k+5).
        run(5, 2'b01, 1'b0, 2'b00);
        run(3, 2'b01, 1'b0, 2'b01);

        // Clean release.
        run(5, 2'b00, 1'b0, 2'b01);
        run(3, 2'b00, 1'b0, 2'b00);

        // Bounce 1,0,1,0 every 2 cycles, then settle high.
        run(2, 2'b01, 1'b0, 2'b00);
        run(2, 2'b00, 1'b0, 2'b00);
        run(2, 2'b01, 1'b0, 2'b00);
        run(2, 2'b00, 1'b0, 2'b00);
        run(5, 2'b01, 1'b0, 2'b00);
        run(3, 2'b01, 1'b0, 2'b01);

        // 3-cycle low pulse (one short of STABLE_CYCLES) is rejected.
        run(3, 2'b00, 1'b0, 2'b01);
        run(8, 2'b01, 1'b0, 2'b01);

        // Full release.
        run(5, 2'b00, 1'b0, 2'b01);
        run(3, 2'b00, 1'b0, 2'b00);

        // Simultaneous press and release on both channels.
        run(5, 2'b11, 1'b0, 2'b00);
        run(3, 2'b11, 1'b0, 2'b11);
        run(5, 2'b00, 1'b0, 2'b11);
        run(3, 2'b00, 1'b0, 2'b00);

        // Staggered presses: channel 1 first, channel 0 two cycles later.
        run(2, 2'b10, 1'b0, 2'b00);
        run(3, 2'b11, 1'b0, 2'b00);
        run(2, 2'b11, 1'b0, 2'b10);
        run(3, 2'b11, 1'b0, 2'b11);
        run(5, 2'b00, 1'b0, 2'b11);
        run(3, 2'b00, 1'b0, 2'b00);

        // Reset two edges into a press; button held through deassertion.
        run(2, 2'b01, 1'b0, 2'b00);
        run(1, 2'b01, 1'b1, 2'b00);
        run(5, 2'b01, 1'b0, 2'b00);
        run(3, 2'b01, 1'b0, 2'b01);

        for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clk);
        if (sb.size() > 0) begin
            miss++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss);
        $finish;
    end

endmodule
